// File: rtl/id_exe_skid_reg.sv
// id_exe_skid_reg: decode->execute pipeline register with a 2-entry skid buffer.
// Main entry drives the outputs; skid entry absorbs one extra beat under back-pressure
// so that in_ready depends only on registered state. Synchronous flush kills all entries.
// Optional feature macro: ID_EXE_PERF_EN adds the stall_cycles / flush_drops counters.
// `DATA_WIDTH sets the default operand width (64 if not defined elsewhere).

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module id_exe_skid_reg #(
    parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_inst_opcode,
    input  logic [DATA_WIDTH-1:0]     in_op1,
    input  logic [DATA_WIDTH-1:0]     in_op2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic                      in_rd_wen,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_inst_opcode,
    output logic [DATA_WIDTH-1:0]     out_op1,
    output logic [DATA_WIDTH-1:0]     out_op2,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_rd_wen
`ifdef ID_EXE_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_drops
`endif
);

    localparam int unsigned OPCODE_WIDTH = 8;
    localparam int unsigned CNT_WIDTH    = 32;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_wen;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;
    logic     accept;
    logic     drain;

    assign in_pl = '{opcode:  in_inst_opcode,
                     op1:     in_op1,
                     op2:     in_op2,
                     rd_addr: in_rd_addr,
                     rd_wen:  in_rd_wen};

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Next-state and payload steering; main is zeroed whenever it goes invalid
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_pl;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_pl;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = in_pl;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State, payload and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_TWO);
        end
    end

    assign out_inst_opcode = main_q.opcode;
    assign out_op1         = main_q.op1;
    assign out_op2         = main_q.op2;
    assign out_rd_addr     = main_q.rd_addr;
    assign out_rd_wen      = main_q.rd_wen;

`ifdef ID_EXE_PERF_EN
    logic [1:0]           drop_n;
    logic [CNT_WIDTH:0]   drop_sum;

    // Number of valid entries a flush would kill this cycle, with saturating sum
    always_comb begin
        drop_n = 2'd0;
        unique case (state_q)
            ST_ONE:  drop_n = 2'd1;
            ST_TWO:  drop_n = 2'd2;
            default: drop_n = 2'd0;
        endcase
        drop_sum = {1'b0, flush_drops} + (CNT_WIDTH+1)'(drop_n);
    end

    // Saturating stall and flush-drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_drops  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (flush) begin
                flush_drops <= drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                                   : drop_sum[CNT_WIDTH-1:0];
            end
        end
    end
`else
    logic unused_cnt_width;
    assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Directed self-checking bench for id_exe_skid_reg.
// Inputs change #1 after the rising edge; outputs are checked at that same point.
`timescale 1ns/1ps

module tb_id_exe_skid_reg;

    localparam int unsigned DW      = 64;
    localparam int unsigned AW      = 5;
    localparam logic [7:0]  INST_ADD = 8'h01;
    localparam logic [7:0]  INST_SUB = 8'h02;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_inst_opcode;
    logic [DW-1:0] in_op1, in_op2;
    logic [AW-1:0] in_rd_addr;
    logic          in_rd_wen;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_inst_opcode;
    logic [DW-1:0] out_op1, out_op2;
    logic [AW-1:0] out_rd_addr;
    logic          out_rd_wen;
`ifdef ID_EXE_PERF_EN
    logic [31:0]   stall_cycles, flush_drops;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    id_exe_skid_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_opcode(in_inst_opcode), .in_op1(in_op1), .in_op2(in_op2),
        .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst_opcode(out_inst_opcode), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen)
`ifdef ID_EXE_PERF_EN
        , .stall_cycles(stall_cycles), .flush_drops(flush_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] opc, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [AW-1:0] rd);
        in_valid       = v;
        in_inst_opcode = opc;
        in_op1         = a;
        in_op2         = b;
        in_rd_addr     = rd;
        in_rd_wen      = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        // Fill both entries, then assert reset between edges
        out_ready = 1'b0;
        drive(1'b1, INST_SUB, 64'h11, 64'h22, 5'd3); step();
        drive(1'b1, INST_SUB, 64'h33, 64'h44, 5'd4); step();
        drive(1'b0, 8'h00, '0, '0, '0);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_op1 !== 64'h11) begin
            n_fail++;
            $display("FAIL reset_prefill: valid=%b ready=%b op1=%h, want 1/0/11",
                     out_valid, in_ready, out_op1);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst_opcode !== 8'h00 ||
            out_op1 !== '0 || out_op2 !== '0 || out_rd_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b ready=%b opc=%h op1=%h, want 0/1/00/0",
                     out_valid, in_ready, out_inst_opcode, out_op1);
        end
        #2;
        rst = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_after: valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, INST_ADD, DW'(i), DW'(2 * i), AW'(i + 1));
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_inst_opcode !== INST_ADD || out_op1 !== DW'(i) ||
                out_op2 !== DW'(2 * i) || out_rd_addr !== AW'(i + 1) || out_rd_wen !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: valid=%b opc=%h op1=%0d op2=%0d rd=%0d, want 1/%h/%0d/%0d/%0d",
                         i, out_valid, out_inst_opcode, out_op1, out_op2, out_rd_addr,
                         INST_ADD, i, 2 * i, i + 1);
            end
        end
        drive(1'b0, 8'h00, '0, '0, '0);
        step();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b1, INST_ADD, 64'hDEAD, 64'hBEEF, 5'd9); step();
        drive(1'b0, 8'hFF, 64'hFFFF, 64'hFFFF, 5'd31);
        in_rd_wen = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_inst_opcode !== 8'h00 || out_op1 !== '0 ||
            out_op2 !== '0 || out_rd_wen !== 1'b0 || out_rd_addr !== '0) begin
            n_fail++;
            $display("FAIL bubble_zero: valid=%b opc=%h op1=%h op2=%h wen=%b, want all 0",
                     out_valid, out_inst_opcode, out_op1, out_op2, out_rd_wen);
        end
        in_rd_wen = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] exp_op1 [6];
        logic          exp_v   [6];
        logic          exp_rdy [6];
        logic          v_in    [6];
        logic          ordy    [6];
        logic [DW-1:0] d_in    [6];
        // cycles: A, B, C blocked, drain A, accept C / drain B, drain C
        v_in    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        d_in    = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'h0};
        ordy    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_op1 = '{64'hA, 64'hA, 64'hA, 64'hB, 64'hC, 64'h0};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(v_in[i], INST_ADD, d_in[i], d_in[i] + 64'h100, 5'd7);
            out_ready = ordy[i];
            step();
            n_tests++;
            if (out_valid !== exp_v[i] || out_op1 !== exp_op1[i] || in_ready !== exp_rdy[i] ||
                (exp_v[i] && out_op2 !== exp_op1[i] + 64'h100)) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b op1=%h op2=%h ready=%b, want %b/%h/%h/%b",
                         i, out_valid, out_op1, out_op2, in_ready, exp_v[i], exp_op1[i],
                         exp_op1[i] + 64'h100, exp_rdy[i]);
            end
        end
        drive(1'b0, 8'h00, '0, '0, '0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, INST_SUB, 64'h5A, 64'h1, 5'd1); step();
        drive(1'b1, INST_SUB, 64'h5B, 64'h2, 5'd2); step();
        // Flush in TWO with a new input presented
        drive(1'b1, INST_SUB, 64'h5D, 64'h3, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, '0, '0, '0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op1 !== '0) begin
            n_fail++;
            $display("FAIL flush_two: valid=%b ready=%b op1=%h, want 0/1/0",
                     out_valid, in_ready, out_op1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak[%0d]: out_valid=%b op1=%h, want 0", i, out_valid, out_op1);
            end
        end
        // Flush in ONE with an accept and a drain in the same cycle
        drive(1'b1, INST_ADD, 64'h77, 64'h1, 5'd5); step();
        drive(1'b1, INST_ADD, 64'h78, 64'h2, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, '0, '0, '0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op1 !== '0) begin
            n_fail++;
            $display("FAIL flush_one: valid=%b ready=%b op1=%h, want 0/1/0",
                     out_valid, in_ready, out_op1);
        end
    endtask

`ifdef ID_EXE_PERF_EN
    task automatic test_perf();
        do_reset();
        n_tests++;
        if (stall_cycles !== 32'd0 || flush_drops !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: stall=%0d drops=%0d, want 0/0", stall_cycles, flush_drops);
        end
        out_ready = 1'b0;
        drive(1'b1, INST_ADD, 64'h1, 64'h1, 5'd1); step();
        drive(1'b1, INST_ADD, 64'h2, 64'h2, 5'd2); step();
        drive(1'b0, 8'h00, '0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if (stall_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall: stall=%0d, want 5", stall_cycles);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if (stall_cycles !== 32'd5 || flush_drops !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_drops: stall=%0d drops=%0d, want 5/2", stall_cycles, flush_drops);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, '0, '0, '0);
        test_reset();
        test_streaming();
        test_bubble();
        test_back_pressure();
        test_flush();
`ifdef ID_EXE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
